// File: rtl/zp_sched.sv
// Zero-point sequencer: per-layer zero-point bank, one lane load per tile,
// then LEN handshaked accumulator beats, a fixed drain, and a done pulse.
module zp_sched #(
  parameter int LANES      = 8,
  parameter int BANK_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int DRAIN_CYC  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(BANK_DEPTH)-1:0] cfg_addr_i,
  input  logic [31:0]                   cfg_data_i,
  input  logic                          start_i,
  input  logic [$clog2(BANK_DEPTH)-1:0] start_sel_i,
  input  logic [LEN_W-1:0]              start_len_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          in_valid_i,
  input  logic [LANES*32-1:0]           in_data_i,
  output logic                          in_ready_o,
  output logic [31:0]                   zp_o,
  output logic                          zp_valid_o,
  output logic                          data_valid_o,
  output logic [LANES*32-1:0]           data_o
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [31:0]      bank_q [BANK_DEPTH];
  logic [LEN_W-1:0] len_q;
  logic [DW-1:0]    drain_q;
  logic [31:0]      zp_rd;
  logic             start_acc;
  logic             accept;

  assign in_ready_o = (state_q == S_STREAM);
  assign accept     = in_valid_i && in_ready_o;
  assign start_acc  = start_i && (state_q == S_IDLE);

  // A same-cycle config write to the selected entry wins over the stored value.
  always_comb begin
    zp_rd = bank_q[start_sel_i];
    if (cfg_we_i && (cfg_addr_i == start_sel_i)) zp_rd = cfg_data_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_LOAD;
      S_LOAD:   state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (accept && (len_q == LEN_W'(1))) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < BANK_DEPTH; i++) bank_q[i] <= '0;
    end else if (cfg_we_i) begin
      bank_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      drain_q      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      zp_valid_o   <= 1'b0;
      zp_o         <= '0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
    end else begin
      state_q    <= state_d;
      busy_o     <= (state_d != S_IDLE);
      done_o     <= (state_q == S_DRAIN) && (state_d == S_IDLE);
      zp_valid_o <= start_acc;

      if (start_acc) begin
        len_q <= start_len_i;
        zp_o  <= zp_rd;
      end else if (accept) begin
        len_q <= len_q - 1'b1;
      end

      if ((state_d == S_DRAIN) && (state_q != S_DRAIN)) drain_q <= DW'(DRAIN_CYC - 1);
      else if (state_q == S_DRAIN)                       drain_q <= drain_q - 1'b1;

      data_valid_o <= accept;
      if (accept) data_o <= in_data_i;
    end
  end

endmodule

// File: tb/tb_zp_sched.sv
// Self-checking bench for zp_sched: randomized tiles checked against a
// transaction-level model (bank array, beat queue, spec latency rules).
module tb_zp_sched;

  localparam int LANES      = 8;
  localparam int BANK_DEPTH = 16;
  localparam int LEN_W      = 16;
  localparam int DRAIN_CYC  = 2;
  localparam int AW         = $clog2(BANK_DEPTH);
  localparam int BW         = LANES * 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we_i;
  logic [AW-1:0] cfg_addr_i;
  logic [31:0]   cfg_data_i;
  logic          start_i;
  logic [AW-1:0] start_sel_i;
  logic [LEN_W-1:0] start_len_i;
  logic          busy_o, done_o, in_valid_i, in_ready_o, zp_valid_o, data_valid_o;
  logic [BW-1:0] in_data_i, data_o;
  logic [31:0]   zp_o;

  always #5 clk = ~clk;

  zp_sched #(.LANES(LANES), .BANK_DEPTH(BANK_DEPTH), .LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .start_i(start_i), .start_sel_i(start_sel_i), .start_len_i(start_len_i),
    .busy_o(busy_o), .done_o(done_o), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .zp_o(zp_o), .zp_valid_o(zp_valid_o),
    .data_valid_o(data_valid_o), .data_o(data_o));

  int checks = 0;
  int errors = 0;

  logic [31:0] model_bank [BANK_DEPTH];
  logic [BW-1:0] q_exp[$];
  logic [BW-1:0] q_got[$];
  logic [31:0]   exp_zp;
  logic [31:0]   obs_zp_val;
  logic [BW-1:0] obs_hold;
  int obs_zp_cnt, obs_zp_t, obs_acc, obs_first_rdy, obs_last_acc, obs_done_t, obs_overlap, obs_busy_bad;

  task automatic rand_beat(output logic [BW-1:0] b);
    for (int k = 0; k < LANES; k++) b[k*32 +: 32] = $urandom();
  endtask

  // Called at a negedge; the write is captured at the following posedge.
  task automatic write_cfg(input int a, input logic [31:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = AW'(a); cfg_data_i = d;
    model_bank[a] = d;
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  // Issues a start at the current negedge (t=0) and observes one negedge per cycle
  // until done_o. vmode: 0 always valid, 1 random valid, 2 fixed 1,0,0,1,1,0,1 pattern.
  task automatic run_tile(input int sel, input int len, input int vmode, input bit const_data,
                          input bit fwd, input logic [31:0] fwd_data,
                          input int wr_t, input int wr_addr, input logic [31:0] wr_data,
                          input int mid_start_t);
    int sc;
    bit v;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    q_exp.delete(); q_got.delete();
    obs_zp_cnt = 0; obs_zp_t = -1; obs_acc = 0; obs_first_rdy = -1; obs_last_acc = -1;
    obs_done_t = -1; obs_overlap = 0; obs_busy_bad = 0; obs_zp_val = '0; obs_hold = '0;
    sc = 0;
    start_i = 1'b1; start_sel_i = AW'(sel); start_len_i = LEN_W'(len);
    if (fwd) begin
      cfg_we_i = 1'b1; cfg_addr_i = AW'(sel); cfg_data_i = fwd_data;
      model_bank[sel] = fwd_data;
    end
    exp_zp = model_bank[sel];
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk);
      start_i = 1'b0; cfg_we_i = 1'b0; in_valid_i = 1'b0;
      if (zp_valid_o) begin obs_zp_cnt++; obs_zp_t = t; obs_zp_val = zp_o; end
      if (data_valid_o) q_got.push_back(data_o);
      if (zp_valid_o && data_valid_o) obs_overlap++;
      if (done_o) begin
        obs_done_t = t; obs_hold = data_o;
        if (busy_o) obs_busy_bad++;
        break;
      end
      if (!busy_o) obs_busy_bad++;
      if (t == wr_t) begin
        cfg_we_i = 1'b1; cfg_addr_i = AW'(wr_addr); cfg_data_i = wr_data;
        model_bank[wr_addr] = wr_data;
      end
      if (t == mid_start_t) begin
        start_i = 1'b1; start_sel_i = AW'(sel); start_len_i = LEN_W'(2);
      end
      v = 1'b0;
      if (in_ready_o) begin
        if (obs_first_rdy < 0) obs_first_rdy = t;
        case (vmode)
          0:       v = 1'b1;
          1:       v = ($urandom_range(0, 1) == 1);
          default: v = pat[sc % 7];
        endcase
        sc++;
      end
      if (const_data) in_data_i = {LANES{32'd1000}};
      else            rand_beat(in_data_i);
      in_valid_i = v;
      if (v && in_ready_o) begin
        q_exp.push_back(in_data_i); obs_acc++; obs_last_acc = t;
      end
    end
  endtask

  function automatic bit beats_differ();
    if (q_got.size() != q_exp.size()) return 1'b1;
    foreach (q_exp[i]) if (q_got[i] !== q_exp[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_done(input int len);
    return (len == 0) ? 2 + DRAIN_CYC : obs_last_acc + 1 + DRAIN_CYC;
  endfunction

  task automatic test_reset();
    checks++; if ({busy_o, done_o, in_ready_o, zp_valid_o, data_valid_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {busy_o, done_o, in_ready_o, zp_valid_o, data_valid_o}); end
    checks++; if (zp_o !== 32'd0) begin errors++; $display("FAIL reset_zp got %h exp 0", zp_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    write_cfg(3, -32'sd128);
    run_tile(3, 4, 0, 1'b1, 1'b0, '0, -1, 0, '0, -1);
    checks++; if (obs_zp_cnt !== 1 || obs_zp_t !== 1) begin errors++;
      $display("FAIL basic_zp_timing got cnt=%0d t=%0d exp cnt=1 t=1", obs_zp_cnt, obs_zp_t); end
    checks++; if (obs_zp_val !== exp_zp) begin errors++;
      $display("FAIL basic_zp_val got %0d exp %0d", $signed(obs_zp_val), $signed(exp_zp)); end
    checks++; if (obs_first_rdy !== 2) begin errors++; $display("FAIL basic_ready_lat got %0d exp 2", obs_first_rdy); end
    checks++; if (obs_acc !== 4 || beats_differ()) begin errors++;
      $display("FAIL basic_beats got acc=%0d fwd=%0d exp 4", obs_acc, q_got.size()); end
    checks++; if (obs_done_t !== obs_last_acc + 3) begin errors++;
      $display("FAIL basic_done got t=%0d exp t=%0d", obs_done_t, obs_last_acc + 3); end
    checks++; if (obs_busy_bad !== 0 || obs_overlap !== 0) begin errors++;
      $display("FAIL basic_busy_overlap got busy_bad=%0d overlap=%0d exp 0 0", obs_busy_bad, obs_overlap); end
    checks++; if (obs_hold !== {LANES{32'd1000}}) begin errors++; $display("FAIL basic_hold got %h exp lanes of 1000", obs_hold); end
  endtask

  task automatic test_stall();
    run_tile(3, 4, 2, 1'b0, 1'b0, '0, -1, 0, '0, -1);
    checks++; if (obs_acc !== 4 || beats_differ()) begin errors++;
      $display("FAIL stall_beats got acc=%0d fwd=%0d exp 4", obs_acc, q_got.size()); end
    checks++; if (obs_done_t !== exp_done(4)) begin errors++;
      $display("FAIL stall_done got %0d exp %0d", obs_done_t, exp_done(4)); end
    checks++; if (obs_hold !== q_exp[q_exp.size()-1]) begin errors++; $display("FAIL stall_hold got %h exp last beat", obs_hold); end
  endtask

  task automatic test_len0();
    write_cfg(0, 32'd7);
    run_tile(0, 0, 0, 1'b0, 1'b0, '0, -1, 0, '0, -1);
    checks++; if (obs_zp_cnt !== 1 || obs_zp_val !== 32'd7) begin errors++;
      $display("FAIL len0_zp got cnt=%0d val=%0d exp 1 7", obs_zp_cnt, obs_zp_val); end
    checks++; if (q_got.size() !== 0 || obs_first_rdy !== -1) begin errors++;
      $display("FAIL len0_nodata got beats=%0d rdy_t=%0d exp 0 -1", q_got.size(), obs_first_rdy); end
    checks++; if (obs_done_t !== 2 + DRAIN_CYC) begin errors++;
      $display("FAIL len0_done got %0d exp %0d", obs_done_t, 2 + DRAIN_CYC); end
  endtask

  task automatic test_forward_and_back_to_back();
    run_tile(5, 6, 1, 1'b0, 1'b1, 32'd42, 4, 5, 32'd99, -1);
    checks++; if (obs_zp_val !== 32'd42) begin errors++; $display("FAIL fwd_zp got %0d exp 42", obs_zp_val); end
    checks++; if (obs_acc !== 6 || beats_differ()) begin errors++;
      $display("FAIL fwd_beats got acc=%0d fwd=%0d exp 6", obs_acc, q_got.size()); end
    // Start driven in the done cycle of the previous tile.
    run_tile(5, 3, 0, 1'b0, 1'b0, '0, -1, 0, '0, -1);
    checks++; if (obs_zp_t !== 1 || obs_zp_val !== 32'd99) begin errors++;
      $display("FAIL b2b_zp got t=%0d val=%0d exp t=1 val=99", obs_zp_t, obs_zp_val); end
    checks++; if (obs_done_t !== exp_done(3) || beats_differ()) begin errors++;
      $display("FAIL b2b_done got %0d exp %0d", obs_done_t, exp_done(3)); end
  endtask

  task automatic test_start_ignored();
    write_cfg(2, 32'hDEAD_BEEF);
    run_tile(2, 5, 1, 1'b0, 1'b0, '0, -1, 0, '0, 3);
    checks++; if (obs_zp_cnt !== 1 || obs_acc !== 5) begin errors++;
      $display("FAIL ignore_start got zp_cnt=%0d acc=%0d exp 1 5", obs_zp_cnt, obs_acc); end
    checks++; if (obs_done_t !== exp_done(5) || beats_differ()) begin errors++;
      $display("FAIL ignore_done got %0d exp %0d", obs_done_t, exp_done(5)); end
  endtask

  task automatic test_random();
    int sel, len;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) write_cfg($urandom_range(0, BANK_DEPTH-1), $urandom());
      sel = $urandom_range(0, BANK_DEPTH-1);
      len = $urandom_range(0, 10);
      run_tile(sel, len, $urandom_range(0, 2), 1'b0, $urandom_range(0, 1) == 1, $urandom(), -1, 0, '0, -1);
      checks++; if (obs_zp_val !== exp_zp || obs_zp_t !== 1) begin errors++;
        $display("FAIL rand_zp[%0d] got %h t=%0d exp %h t=1", n, obs_zp_val, obs_zp_t, exp_zp); end
      checks++; if (obs_acc !== len || beats_differ() || obs_overlap !== 0) begin errors++;
        $display("FAIL rand_beats[%0d] got acc=%0d fwd=%0d exp %0d", n, obs_acc, q_got.size(), len); end
      checks++; if (obs_done_t !== exp_done(len) || obs_busy_bad !== 0) begin errors++;
        $display("FAIL rand_done[%0d] got %0d busy_bad=%0d exp %0d", n, obs_done_t, obs_busy_bad, exp_done(len)); end
    end
  endtask

  task automatic test_reset_mid();
    int acc, dones;
    write_cfg(9, 32'd1234);
    start_i = 1'b1; start_sel_i = AW'(9); start_len_i = LEN_W'(6);
    acc = 0;
    for (int t = 1; t < 50 && acc < 2; t++) begin
      @(negedge clk);
      start_i = 1'b0; in_valid_i = 1'b0;
      if (in_ready_o) begin rand_beat(in_data_i); in_valid_i = 1'b1; acc++; end
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if ({busy_o, done_o, in_ready_o, zp_valid_o, data_valid_o} !== 5'b0 || zp_o !== '0 || data_o !== '0) begin
      errors++; $display("FAIL rstmid_outputs got ctrl=%b zp=%h exp all 0",
                         {busy_o, done_o, in_ready_o, zp_valid_o, data_valid_o}, zp_o); end
    for (int i = 0; i < BANK_DEPTH; i++) model_bank[i] = '0;
    in_valid_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done_o || busy_o) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_nodone got %0d active cycles exp 0", dones); end
    run_tile(9, 1, 0, 1'b0, 1'b0, '0, -1, 0, '0, -1);
    checks++; if (obs_zp_val !== exp_zp || obs_done_t !== exp_done(1)) begin errors++;
      $display("FAIL rstmid_bank got zp=%h done_t=%0d exp zp=%h done_t=%0d", obs_zp_val, obs_done_t, exp_zp, exp_done(1)); end
  endtask

  initial begin
    rst = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    start_i = 1'b0; start_sel_i = '0; start_len_i = '0;
    in_valid_i = 1'b0; in_data_i = '0;
    for (int i = 0; i < BANK_DEPTH; i++) model_bank[i] = '0;
    @(negedge clk); @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_forward_and_back_to_back();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
